// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;
    localparam logic UART_IDLE_LVL   = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // Resolve metastability over two stages; reset to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= UART_IDLE_LVL;
            s2_q <= UART_IDLE_LVL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled mid-bit sampling, sticky ready, error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enb,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state, counters and flags; a good stop sample overrides rdy_clr.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        fe_d    = fe_q;
        ov_d    = ov_q;
        if (rdy_clr) begin
            rdy_d = 1'b0;
            ov_d  = 1'b0;
        end
        if (enb) begin
            tick_d = tick_q + 1'b1;
            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    if (!rx_s) state_d = START;
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_d = STOP;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (rx_s) begin
                            data_d = shift_q;
                            rdy_d  = 1'b1;
                            fe_d   = 1'b0;
                            if (rdy_q && !rdy_clr) ov_d = 1'b1;
                        end else begin
                            fe_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign rdy       = rdy_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = fe_q;
    assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, corner sequences, random loopback.
module tb_uart_receiver;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    bit enb_rand = 0;
    int ecnt     = 0;

    typedef struct {
        logic [7:0] d;
        bit         stop;
        bit         clr;
        logic [7:0] e_data;
        bit         e_rdy;
        bit         e_fe;
        bit         e_ov;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] exp_q[$];

    uart_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enb       (enb),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data_out  (data_out),
        .rdy       (rdy),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: every 4th clk in directed tests, random density in loopback.
    initial begin
        enb = 0;
        forever begin
            @(posedge clk);
            #1;
            if (enb_rand) begin
                enb = ($urandom_range(0, 3) != 0);
            end else begin
                enb  = (ecnt == 3);
                ecnt = (ecnt + 1) % 4;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_enb();
        do @(posedge clk); while (!enb);
    endtask

    task automatic drive_bit(input logic v, input int n);
        #1 rx = v;
        repeat (n) wait_enb();
    endtask

    // Loopback serializer: start, LSB-first data, stop; each bit 16 ticks.
    task automatic tx_byte(input logic [7:0] b);
        drive_bit(1'b0, 16);
        for (int j = 0; j < 8; j++) drive_bit(b[j], 16);
        drive_bit(1'b1, 16);
    endtask

    // Directed frame with tick-exact access to the stop-bit mid sample (enb every 4 clk).
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit clr_at, input bit chk_lat);
        wait_enb();
        drive_bit(1'b0, 16);
        for (int j = 0; j < 8; j++) drive_bit(d[j], 16);
        #1 rx = stop;
        repeat (8) wait_enb();
        repeat (3) @(posedge clk);
        #1;
        if (chk_lat) chk("lat_pre_rdy", rdy, 0);
        if (clr_at) rdy_clr = 1;
        @(posedge clk);
        chk("stop_tick_enb", enb, 1);
        #1 rdy_clr = 0;
        if (chk_lat) chk("lat_post_rdy", rdy, 1);
        repeat (7) wait_enb();
        #1 rx = 1;
        repeat (24) wait_enb();
    endtask

    task automatic chk_state(input string nm, input logic [7:0] e_d, input bit e_r,
                             input bit e_f, input bit e_o, input bit e_b);
        #1;
        chk({nm, "_data"}, data_out, e_d);
        chk({nm, "_rdy"}, rdy, e_r);
        chk({nm, "_fe"}, frame_err, e_f);
        chk({nm, "_ov"}, overrun, e_o);
        chk({nm, "_busy"}, busy, e_b);
    endtask

    initial begin
        int  got;
        int  post;
        bit  tx_done;
        tbl[0] = '{8'hA5, 1, 0, 8'hA5, 1, 0, 0};
        tbl[1] = '{8'h3C, 0, 1, 8'hA5, 0, 1, 0};
        tbl[2] = '{8'h5A, 1, 0, 8'h5A, 1, 0, 0};
        tbl[3] = '{8'h00, 1, 1, 8'h00, 1, 0, 0};
        tbl[4] = '{8'h11, 1, 1, 8'h11, 1, 0, 0};
        tbl[5] = '{8'h22, 1, 0, 8'h22, 1, 0, 1};
        tbl[6] = '{8'hFF, 0, 0, 8'h22, 1, 1, 1};

        rst_n = 0; rx = 1; rdy_clr = 0;
        // Reset held while rx toggles.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rx = i[0];
        end
        chk_state("rst", 8'h00, 0, 0, 0, 0);
        #1 rx = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (40) @(posedge clk);
        chk_state("rel", 8'h00, 0, 0, 0, 0);

        // Directed frame table.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].clr) begin
                @(posedge clk);
                #1 rdy_clr = 1;
                @(posedge clk);
                #1 rdy_clr = 0;
            end
            send_frame(tbl[i].d, tbl[i].stop, 0, i == 0);
            chk_state($sformatf("row%0d", i), tbl[i].e_data, tbl[i].e_rdy, tbl[i].e_fe, tbl[i].e_ov, 0);
        end

        // rdy_clr coincident with a good stop sample: set wins.
        send_frame(8'h33, 1, 1, 0);
        chk_state("prio", 8'h33, 1, 0, 0, 0);

        // Short start glitch is rejected at mid-start.
        wait_enb();
        #1 rx = 0;
        repeat (5) wait_enb();
        #1 chk("glitch_busy", busy, 1);
        rx = 1;
        repeat (20) wait_enb();
        chk_state("glitch", 8'h33, 1, 0, 0, 0);

        // Reset in the middle of a frame discards it.
        wait_enb();
        #1 rx = 0;
        repeat (40) wait_enb();
        #1 chk("midrst_busy_pre", busy, 1);
        rst_n = 0;
        chk_state("midrst", 8'h00, 0, 0, 0, 0);
        rx = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (20) wait_enb();
        chk_state("midrst_rel", 8'h00, 0, 0, 0, 0);
        send_frame(8'hC3, 1, 0, 1);
        chk_state("after_rst", 8'hC3, 1, 0, 0, 0);
        @(posedge clk);
        #1 rdy_clr = 1;
        @(posedge clk);
        #1 rdy_clr = 0;
        chk("clr_rdy", rdy, 0);

        // Random back-to-back loopback against an expected-byte queue.
        enb_rand = 1;
        got = 0; post = 0; tx_done = 0;
        fork
            begin
                wait_enb();
                for (int i = 0; i < 256; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    tx_byte(b);
                end
                tx_done = 1;
            end
            begin
                while (!(tx_done && (got == 256 || post > 3000))) begin
                    @(negedge clk);
                    if (tx_done) post++;
                    if (rdy_clr) begin
                        rdy_clr = 0;
                    end else if (rdy) begin
                        if (exp_q.size() == 0) begin
                            chk("lb_unexpected", 1, 0);
                        end else begin
                            chk($sformatf("lb_byte%0d", got), data_out, exp_q.pop_front());
                        end
                        chk("lb_fe", frame_err, 0);
                        chk("lb_ov", overrun, 0);
                        got++;
                        rdy_clr = 1;
                    end
                end
                rdy_clr = 0;
            end
        join
        chk("lb_count", got, 256);
        repeat (4) @(posedge clk);
        chk_state("lb_end", exp_q.size() == 0 ? data_out : 8'hxx, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
